des_cbc_unchain: RTL and testbench



---
 rtl/des_cbc_unchain.sv | 100 ++++++++++
 tb/tb_des_cbc_unchain.sv | 290 +++++++++++++++++++++++++++++
 2 files changed

// File: rtl/des_cbc_unchain.sv
// CBC unchain stage behind the DES decrypt core: XOR with previous ciphertext/IV, emit 8 bytes.
// Optional ECB pass-through (ecb_mode port) when DES_CBC_ECB_BYPASS_EN is defined.
//
// state | meaning
// IDLE  | waiting for a decrypted block; iv_load honoured here
// SHIFT | presenting the unchained block one byte per accepted handshake
module des_cbc_unchain #(
  parameter bit MSB_FIRST = 1'b1
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        iv_load,
  input  logic [63:0] iv,
  input  logic        blk_valid,
  output logic        blk_ready,
  input  logic        blk_last,
  input  logic [63:0] dec_block,
  input  logic [63:0] ct_block,
`ifdef DES_CBC_ECB_BYPASS_EN
  input  logic        ecb_mode,
`endif
  output logic        byte_valid,
  input  logic        byte_ready,
  output logic [7:0]  byte_data,
  output logic        byte_last,
  output logic        busy
);

  typedef enum logic {
    IDLE  = 1'b0,
    SHIFT = 1'b1
  } state_t;

  state_t      state;
  logic [63:0] iv_reg;
  logic [63:0] chain_reg;
  logic [63:0] out_reg;
  logic [2:0]  cnt;
  logic        last_reg;
  logic        bypass;
  logic [63:0] out_shift;

`ifdef DES_CBC_ECB_BYPASS_EN
  assign bypass = ecb_mode;
`else
  assign bypass = 1'b0;
`endif

  // Zero fill keeps byte_data at 0 once a block has fully drained.
  assign out_shift = MSB_FIRST ? {out_reg[55:0], 8'h00} : {8'h00, out_reg[63:8]};
  assign byte_data = MSB_FIRST ? out_reg[63:56] : out_reg[7:0];
  assign byte_last = last_reg && (cnt == 3'd7);

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state      <= IDLE;
      iv_reg     <= 64'h0;
      chain_reg  <= 64'h0;
      out_reg    <= 64'h0;
      cnt        <= 3'd0;
      last_reg   <= 1'b0;
      blk_ready  <= 1'b1;
      byte_valid <= 1'b0;
      busy       <= 1'b0;
    end else if (state == IDLE) begin
      if (blk_valid) begin
        out_reg    <= bypass ? dec_block : (dec_block ^ chain_reg);
        last_reg   <= blk_last;
        cnt        <= 3'd0;
        state      <= SHIFT;
        blk_ready  <= 1'b0;
        byte_valid <= 1'b1;
        busy       <= 1'b1;
        // Last block of a message re-arms the chain with the stored IV.
        if (!bypass) begin
          chain_reg <= blk_last ? iv_reg : ct_block;
        end
      end
      // Placed after the handshake update so a simultaneous load wins.
      if (iv_load) begin
        iv_reg    <= iv;
        chain_reg <= iv;
      end
    end else begin
      if (byte_ready) begin
        out_reg <= out_shift;
        if (cnt == 3'd7) begin
          state      <= IDLE;
          cnt        <= 3'd0;
          blk_ready  <= 1'b1;
          byte_valid <= 1'b0;
          busy       <= 1'b0;
        end else begin
          cnt <= cnt + 3'd1;
        end
      end
    end
  end

endmodule

// File: tb/tb_des_cbc_unchain.sv
// Bench for des_cbc_unchain: MSB-first and LSB-first instances driven in lockstep against a CBC model.
module tb_des_cbc_unchain;

  logic        clk = 1'b0;
  logic        rst_n = 1'b1;
  logic        iv_load = 1'b0;
  logic [63:0] iv = 64'h0;
  logic        blk_valid = 1'b0;
  logic        blk_last = 1'b0;
  logic [63:0] dec_block = 64'h0;
  logic [63:0] ct_block = 64'h0;
  logic        ecb_mode = 1'b0;
  logic        byte_ready = 1'b1;

  logic       blk_ready_a, byte_valid_a, byte_last_a, busy_a;
  logic [7:0] byte_data_a;
  logic       blk_ready_b, byte_valid_b, byte_last_b, busy_b;
  logic [7:0] byte_data_b;

  des_cbc_unchain #(.MSB_FIRST(1'b1)) dut_a (
    .clk(clk), .rst_n(rst_n), .iv_load(iv_load), .iv(iv),
    .blk_valid(blk_valid), .blk_ready(blk_ready_a), .blk_last(blk_last),
    .dec_block(dec_block), .ct_block(ct_block),
`ifdef DES_CBC_ECB_BYPASS_EN
    .ecb_mode(ecb_mode),
`endif
    .byte_valid(byte_valid_a), .byte_ready(byte_ready), .byte_data(byte_data_a),
    .byte_last(byte_last_a), .busy(busy_a)
  );

  des_cbc_unchain #(.MSB_FIRST(1'b0)) dut_b (
    .clk(clk), .rst_n(rst_n), .iv_load(iv_load), .iv(iv),
    .blk_valid(blk_valid), .blk_ready(blk_ready_b), .blk_last(blk_last),
    .dec_block(dec_block), .ct_block(ct_block),
`ifdef DES_CBC_ECB_BYPASS_EN
    .ecb_mode(ecb_mode),
`endif
    .byte_valid(byte_valid_b), .byte_ready(byte_ready), .byte_data(byte_data_b),
    .byte_last(byte_last_b), .busy(busy_b)
  );

  always #5 clk = ~clk;

  int vectors = 0;
  int miscompares = 0;

  logic [7:0]  exp_a[$];
  logic [7:0]  exp_b[$];
  bit          exp_l[$];
  logic [7:0]  rx_a[$];
  logic [7:0]  rx_b[$];
  logic [63:0] m_iv = 64'h0;
  logic [63:0] m_prev = 64'h0;

  task automatic check1(input string nm, input logic act, input logic exp);
    vectors++;
    if (act !== exp) begin
      miscompares++;
      $display("FAIL %s: got %b expected %b at %0t", nm, act, exp, $time);
    end
  endtask

  task automatic check8(input string nm, input logic [7:0] act, input logic [7:0] exp);
    vectors++;
    if (act !== exp) begin
      miscompares++;
      $display("FAIL %s: got %h expected %h at %0t", nm, act, exp, $time);
    end
  endtask

  task automatic check64(input string nm, input logic [63:0] act, input logic [63:0] exp);
    vectors++;
    if (act !== exp) begin
      miscompares++;
      $display("FAIL %s: got %h expected %h at %0t", nm, act, exp, $time);
    end
  endtask

  // Cycle-by-cycle compare against the expected byte stream of both instances.
  initial begin
    logic ev;
    forever begin
      @(negedge clk);
      if (rst_n === 1'b1) begin
        ev = (exp_a.size() != 0);
        check1("byte_valid_a", byte_valid_a, ev);
        check1("byte_valid_b", byte_valid_b, ev);
        check1("busy_a", busy_a, ev);
        check1("blk_ready_a", blk_ready_a, !ev);
        check1("blk_ready_b", blk_ready_b, !ev);
        if (ev) begin
          check8("byte_data_a", byte_data_a, exp_a[0]);
          check8("byte_data_b", byte_data_b, exp_b[0]);
          check1("byte_last_a", byte_last_a, exp_l[0]);
          check1("byte_last_b", byte_last_b, exp_l[0]);
          if (byte_ready) begin
            rx_a.push_back(byte_data_a);
            rx_b.push_back(byte_data_b);
            void'(exp_a.pop_front());
            void'(exp_b.pop_front());
            void'(exp_l.pop_front());
          end
        end
      end
    end
  end

  task automatic check_reset_outputs(input string nm);
    check1({nm, "_byte_valid"}, byte_valid_a | byte_valid_b, 1'b0);
    check8({nm, "_byte_data_a"}, byte_data_a, 8'h00);
    check8({nm, "_byte_data_b"}, byte_data_b, 8'h00);
    check1({nm, "_byte_last"}, byte_last_a | byte_last_b, 1'b0);
    check1({nm, "_busy"}, busy_a | busy_b, 1'b0);
    check1({nm, "_blk_ready"}, blk_ready_a & blk_ready_b, 1'b1);
  endtask

  task automatic load_iv(input logic [63:0] v);
    iv_load = 1'b1;
    iv = v;
    @(posedge clk); #1;
    iv_load = 1'b0;
    m_iv = v;
    m_prev = v;
  endtask

  // Plaintext = decrypted block XOR previous ciphertext (IV for a message's first block).
  task automatic send_blk(input logic [63:0] dec, input logic [63:0] ct, input bit last,
                          input bit ecb, input bit ivl, input logic [63:0] ivv);
    logic [63:0] w;
    int n;
    w = ecb ? dec : (dec ^ m_prev);
    dec_block = dec;
    ct_block = ct;
    blk_last = last;
    ecb_mode = ecb;
    iv_load = ivl;
    iv = ivv;
    blk_valid = 1'b1;
    n = 0;
    while (blk_ready_a !== 1'b1 && n < 40) begin
      @(posedge clk); #1;
      n++;
    end
    if (n >= 40) begin
      check1("blk_ready_timeout", blk_ready_a, 1'b1);
      blk_valid = 1'b0;
      iv_load = 1'b0;
      return;
    end
    @(posedge clk); #1;
    blk_valid = 1'b0;
    iv_load = 1'b0;
    ecb_mode = 1'b0;
    for (int k = 0; k < 8; k++) begin
      exp_a.push_back(w[63-8*k -: 8]);
      exp_b.push_back(w[8*k +: 8]);
      exp_l.push_back(last && (k == 7));
    end
    if (ivl) begin
      m_iv = ivv;
      m_prev = ivv;
    end else if (!ecb) begin
      m_prev = last ? m_iv : ct;
    end
  endtask

  task automatic wait_drain();
    int n;
    n = 0;
    while (exp_a.size() != 0 && n < 80) begin
      @(posedge clk); #1;
      n++;
    end
    check64("drain_timeout", 64'(exp_a.size()), 64'd0);
    @(negedge clk);
  endtask

  // Received bytes in emission order packed first-byte-at-top, pinned to hand-computed words.
  task automatic check_word(input string nm, input int base, input logic [63:0] exp, input bit lsb);
    logic [63:0] act;
    logic [7:0] b;
    act = 64'h0;
    for (int k = 0; k < 8; k++) begin
      if (lsb) b = (base + k < rx_b.size()) ? rx_b[base+k] : 8'hxx;
      else     b = (base + k < rx_a.size()) ? rx_a[base+k] : 8'hxx;
      act[63-8*k -: 8] = b;
    end
    check64(nm, act, exp);
  endtask

  initial begin
    #100000;
    $display("FAIL watchdog: simulation did not finish, got timeout expected completion");
    $fatal(1);
  end

  initial begin
    #1 rst_n = 1'b0;
    #1 check_reset_outputs("por");
    repeat (2) @(posedge clk);
    #1 rst_n = 1'b1;

    // Block XORed with identical IV gives all zeros; the next message reuses the IV.
    rx_a.delete(); rx_b.delete();
    load_iv(64'h0123456789ABCDEF);
    send_blk(64'h0123456789ABCDEF, 64'hFEDCBA9876543210, 1'b1, 1'b0, 1'b0, 64'h0);
    send_blk(64'h0123456789ABCDEF, 64'h0F0F0F0F0F0F0F0F, 1'b1, 1'b0, 1'b0, 64'h0);
    wait_drain();
    check_word("t1_zero", 0, 64'h0000000000000000, 1'b0);
    check_word("t1_rearm", 8, 64'h0000000000000000, 1'b0);

    // Two-block message, with an iv_load pulse during SHIFT that must be ignored.
    rx_a.delete(); rx_b.delete();
    load_iv(64'h0);
    send_blk(64'h1122334455667788, 64'hFFFFFFFFFFFFFFFF, 1'b0, 1'b0, 1'b0, 64'h0);
    iv_load = 1'b1;
    iv = 64'hDEADBEEFDEADBEEF;
    @(posedge clk); #1;
    iv_load = 1'b0;
    iv = 64'h0;
    send_blk(64'hFFFF0000FFFF0000, 64'h123456789ABCDEF0, 1'b1, 1'b0, 1'b0, 64'h0);
    send_blk(64'h0F0F0F0F0F0F0F0F, 64'h1111111111111111, 1'b1, 1'b0, 1'b0, 64'h0);
    wait_drain();
    check_word("t2_b1_msb", 0, 64'h1122334455667788, 1'b0);
    check_word("t2_b2_msb", 8, 64'h0000FFFF0000FFFF, 1'b0);
    check_word("t2_b1_lsb", 0, 64'h8877665544332211, 1'b1);
    check_word("t2_b2_lsb", 8, 64'hFFFF0000FFFF0000, 1'b1);
    check_word("t2_ivload_ignored", 16, 64'h0F0F0F0F0F0F0F0F, 1'b0);

    // Sink stalls three cycles while the fifth byte (0x55) is presented.
    rx_a.delete(); rx_b.delete();
    send_blk(64'h1122334455667788, 64'hAAAAAAAAAAAAAAAA, 1'b1, 1'b0, 1'b0, 64'h0);
    repeat (4) @(posedge clk);
    #1 byte_ready = 1'b0;
    repeat (3) begin
      @(negedge clk);
      check8("stall_data", byte_data_a, 8'h55);
      check1("stall_blk_ready", blk_ready_a, 1'b0);
    end
    @(posedge clk);
    #1 byte_ready = 1'b1;
    wait_drain();
    check_word("t3_stall", 0, 64'h1122334455667788, 1'b0);

    // Reset after three bytes discards the block and clears the IV.
    load_iv(64'hA5A5A5A5A5A5A5A5);
    send_blk(64'h0102030405060708, 64'h1111111111111111, 1'b0, 1'b0, 1'b0, 64'h0);
    repeat (3) @(posedge clk);
    #1 rst_n = 1'b0;
    exp_a.delete(); exp_b.delete(); exp_l.delete();
    m_iv = 64'h0;
    m_prev = 64'h0;
    #1 check_reset_outputs("midrst");
    @(posedge clk);
    #1 rst_n = 1'b1;
    rx_a.delete(); rx_b.delete();
    send_blk(64'h0102030405060708, 64'h2222222222222222, 1'b1, 1'b0, 1'b0, 64'h0);
    wait_drain();
    check_word("t4_after_reset", 0, 64'h0102030405060708, 1'b0);

    // iv_load coinciding with a block handshake: block uses old chain, IV takes the new value.
    rx_a.delete(); rx_b.delete();
    load_iv(64'h0F1E2D3C4B5A6978);
    send_blk(64'h1111111111111111, 64'h2222222222222222, 1'b0, 1'b0, 1'b0, 64'h0);
    send_blk(64'h3333333333333333, 64'h4444444444444444, 1'b0, 1'b0, 1'b1, 64'h5555555555555555);
    send_blk(64'h6666666666666666, 64'h7777777777777777, 1'b1, 1'b0, 1'b0, 64'h0);
    send_blk(64'h7777777777777777, 64'h8888888888888888, 1'b1, 1'b0, 1'b0, 64'h0);
    wait_drain();
    check_word("t5_b1", 0, 64'h1E0F3C2D5A4B7869, 1'b0);
    check_word("t5_b2_old_chain", 8, 64'h1111111111111111, 1'b0);
    check_word("t5_b3_new_iv", 16, 64'h3333333333333333, 1'b0);
    check_word("t5_b4_rearm", 24, 64'h2222222222222222, 1'b0);

`ifdef DES_CBC_ECB_BYPASS_EN
    // ECB block passes straight through and leaves the chain on the IV.
    rx_a.delete(); rx_b.delete();
    load_iv(64'hAAAAAAAAAAAAAAAA);
    send_blk(64'h1122334455667788, 64'hFFFFFFFFFFFFFFFF, 1'b0, 1'b1, 1'b0, 64'h0);
    send_blk(64'h0000000000000000, 64'h1234123412341234, 1'b1, 1'b0, 1'b0, 64'h0);
    wait_drain();
    check_word("t6_ecb", 0, 64'h1122334455667788, 1'b0);
    check_word("t6_chain_kept", 8, 64'hAAAAAAAAAAAAAAAA, 1'b0);
`endif

    repeat (2) @(negedge clk);
    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
